// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: pattern modes and bounce direction.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_UP = 2'd0,
    MODE_ROT_DN = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  typedef enum logic {
    UP = 1'b0,
    DN = 1'b1
  } dir_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler that produces a one-cycle tick every PERIOD_CYCLES
// enabled clocks.
//   clk  : clock
//   rst  : async active-high reset
//   en   : count enable; when low the count holds and no tick is produced
//   tick : high in the cycle where count == PERIOD_CYCLES-1 and en is high
module tick_prescaler #(
  parameter int PERIOD_CYCLES = 6000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int              CW   = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     count <= '0;
    else if (en) count <= (count == LAST) ? '0 : count + CW'(1);
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern generator. Each prescaler tick advances the selected pattern
// (rotate up/down, bounce, all-blink), toggles heartbeat and fires step_strobe.
//   clk, rst    : clock, async active-high reset
//   mode        : pattern select, sampled only on a tick
//   pause       : freezes prescaler and all pattern state
//   leds        : LED drive, decoded from registered state only
//   heartbeat   : toggles on every tick
//   step_strobe : one-cycle pulse following each tick
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS      = 4,
  parameter int PERIOD_CYCLES = 6000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] leds,
  output logic                heartbeat,
  output logic                step_strobe
);

  localparam int            IW       = $clog2(NUM_LEDS);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_LEDS - 1);

  logic          tick;
  logic [IW-1:0] idx_q, idx_d;
  dir_t          dir_q, dir_d;
  mode_t         mode_q, mode_d;
  logic          hb_q, hb_d;
  logic          strobe_q;

  tick_prescaler #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (~pause),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      dir_q    <= UP;
      mode_q   <= MODE_ROT_UP;
      hb_q     <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      hb_q     <= hb_d;
      strobe_q <= tick;
    end
  end

  // The freshly sampled mode drives this tick's update so a mode switch
  // never leaves a half-applied step.
  always_comb begin
    idx_d  = idx_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    hb_d   = hb_q;
    if (tick) begin
      mode_d = mode_t'(mode);
      hb_d   = ~hb_q;
      dir_d  = UP;  // any non-bounce step re-arms bounce to start upward
      case (mode_d)
        MODE_ROT_UP: idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        MODE_ROT_DN: idx_d = (idx_q == '0) ? IDX_LAST : idx_q - IW'(1);
        MODE_BOUNCE: begin
          if (dir_q == UP) begin
            if (idx_q == IDX_LAST) begin
              dir_d = DN;
              idx_d = IDX_LAST - IW'(1);
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            if (idx_q == '0) begin
              idx_d = IW'(1);
            end else begin
              dir_d = DN;
              idx_d = idx_q - IW'(1);
            end
          end
        end
        default: idx_d = idx_q;  // blink holds position
      endcase
    end
  end

  always_comb begin
    if (mode_q == MODE_BLINK) leds = {NUM_LEDS{hb_q}};
    else                      leds = NUM_LEDS'(1) << idx_q;
  end

  assign heartbeat   = hb_q;
  assign step_strobe = strobe_q;

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       pause;
  logic [3:0] leds;
  logic       heartbeat;
  logic       step_strobe;

  int nvec = 0;
  int nerr = 0;

  led_sequencer #(.NUM_LEDS(4), .PERIOD_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .pause       (pause),
    .leds        (leds),
    .heartbeat   (heartbeat),
    .step_strobe (step_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // One full step: three quiet edges, then the tick edge.
  task automatic do_step(input string tag, input logic [3:0] exp_leds, input logic exp_hb);
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk({tag, " quiet strobe"}, {31'd0, step_strobe}, 32'd0);
    end
    edge1();
    chk({tag, " strobe"}, {31'd0, step_strobe}, 32'd1);
    chk({tag, " leds"},   {28'd0, leds},        {28'd0, exp_leds});
    chk({tag, " hb"},     {31'd0, heartbeat},   {31'd0, exp_hb});
  endtask

  task automatic do_reset(input logic [1:0] m);
    #2 rst = 1'b1;
    mode = m;
    #1;
    chk("rst leds",   {28'd0, leds},        32'h1);
    chk("rst hb",     {31'd0, heartbeat},   32'd0);
    chk("rst strobe", {31'd0, step_strobe}, 32'd0);
    edge1();
    edge1();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; pause = 1'b0;
    edge1();

    // Rotate up from reset
    do_reset(2'd0);
    do_step("up1", 4'b0010, 1'b1);
    do_step("up2", 4'b0100, 1'b0);
    do_step("up3", 4'b1000, 1'b1);
    do_step("up4", 4'b0001, 1'b0);

    // Rotate down
    do_reset(2'd1);
    do_step("dn1", 4'b1000, 1'b1);
    do_step("dn2", 4'b0100, 1'b0);
    do_step("dn3", 4'b0010, 1'b1);
    do_step("dn4", 4'b0001, 1'b0);

    // Bounce, then async reset mid-cycle while heading down
    do_reset(2'd2);
    do_step("bA1", 4'b0010, 1'b1);
    do_step("bA2", 4'b0100, 1'b0);
    do_step("bA3", 4'b1000, 1'b1);
    do_step("bA4", 4'b0100, 1'b0);
    do_step("bA5", 4'b0010, 1'b1);
    edge1();
    #3 rst = 1'b1;
    #1;
    chk("async leds", {28'd0, leds},      32'h1);
    chk("async hb",   {31'd0, heartbeat}, 32'd0);
    #2 rst = 1'b0;
    do_step("b1", 4'b0010, 1'b1);
    do_step("b2", 4'b0100, 1'b0);
    do_step("b3", 4'b1000, 1'b1);
    do_step("b4", 4'b0100, 1'b0);
    do_step("b5", 4'b0010, 1'b1);
    do_step("b6", 4'b0001, 1'b0);
    do_step("b7", 4'b0010, 1'b1);

    // Blink from held index 2, then back to rotate up
    do_reset(2'd0);
    do_step("k1", 4'b0010, 1'b1);
    do_step("k2", 4'b0100, 1'b0);
    mode = 2'd3;
    do_step("k3", 4'b1111, 1'b1);
    do_step("k4", 4'b0000, 1'b0);
    do_step("k5", 4'b1111, 1'b1);
    mode = 2'd0;
    do_step("k6", 4'b1000, 1'b0);

    // Pause at count=2 for 10 cycles
    edge1();
    edge1();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      edge1();
      chk("pause strobe", {31'd0, step_strobe}, 32'd0);
      chk("pause leds",   {28'd0, leds},        32'h8);
      chk("pause hb",     {31'd0, heartbeat},   32'd0);
    end
    pause = 1'b0;
    edge1();
    chk("resume quiet", {31'd0, step_strobe}, 32'd0);
    edge1();
    chk("resume strobe", {31'd0, step_strobe}, 32'd1);
    chk("resume leds",   {28'd0, leds},        32'h1);
    chk("resume hb",     {31'd0, heartbeat},   32'd1);
    edge1();
    chk("strobe width",  {31'd0, step_strobe}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
